// File: rtl/evm_pkg.sv
// Shared state encoding and saturating-increment helper for the voting machine.
// No latency or backpressure of its own; used by evm_param and evm_max_scan.
package evm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_SCAN   = 2'd2,
        ST_DONE   = 2'd3
    } evm_state_t;

    // Widest counter the helper handles; callers zero-extend and truncate back.
    localparam int SAT_W = 64;

    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v, input int w);
        logic [SAT_W-1:0] maxv;
        maxv = (w >= SAT_W) ? '1 : ((SAT_W'(1) << w) - SAT_W'(1));
        return (v >= maxv) ? v : v + SAT_W'(1);
    endfunction

endpackage

// File: rtl/evm_max_scan.sv
// Sequential argmax over NCAND tallies, one per cycle; o_done pulses NCAND cycles after i_start.
// No backpressure: tallies must stay stable while o_busy is high.
module evm_max_scan
    import evm_pkg::*;
#(
    parameter int NCAND = 4,
    parameter int CW    = 32,
    parameter int SELW  = $clog2(NCAND)
) (
    input  logic                  i_core_clk,
    input  logic                  i_arst_n,
    input  logic                  i_start,
    input  logic [NCAND*CW-1:0]   i_tally,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [SELW-1:0]       o_best_idx,
    output logic                  o_tie
);

    localparam logic [SELW-1:0] LAST = SELW'(NCAND - 1);

    logic [SELW-1:0] r_idx;
    logic            r_busy;
    logic            r_done;
    logic [SELW-1:0] r_best_idx;
    logic [CW-1:0]   r_best_cnt;
    logic            r_tie;
    logic [CW-1:0]   w_cur;

    assign w_cur = i_tally[r_idx*CW +: CW];

    always_ff @(posedge i_core_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_idx      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_best_idx <= '0;
            r_best_cnt <= '0;
            r_tie      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_busy <= 1'b1;
                r_idx  <= '0;
            end else if (r_busy) begin
                // Strict '>' keeps the lowest index on equal counts.
                if (r_idx == '0) begin
                    r_best_idx <= '0;
                    r_best_cnt <= w_cur;
                    r_tie      <= 1'b0;
                end else if (w_cur > r_best_cnt) begin
                    r_best_idx <= r_idx;
                    r_best_cnt <= w_cur;
                    r_tie      <= 1'b0;
                end else if (w_cur == r_best_cnt) begin
                    r_tie      <= 1'b1;
                end
                if (r_idx == LAST) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end else begin
                    r_idx <= r_idx + SELW'(1);
                end
            end
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_best_idx = r_best_idx;
    assign o_tie      = r_tie;

endmodule

// File: rtl/evm_param.sv
// NCAND-candidate voting machine: 1-cycle vote ACK/ERR, results NCAND+1 cycles after CLOSE.
// Backpressure: VOTE_READY low outside ACCEPT and until VOTE_VALID drops after each vote.
module evm_param
    import evm_pkg::*;
#(
    parameter  int NCAND = 4,
    parameter  int CW    = 32,
    localparam int SELW  = $clog2(NCAND)
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 OPEN,
    input  logic                 CLOSE,
    input  logic                 VOTE_VALID,
    input  logic [SELW-1:0]      VOTE_SEL,
    output logic                 VOTE_READY,
    output logic                 VOTE_ACK,
    output logic                 VOTE_ERR,
    input  logic [SELW-1:0]      RD_SEL,
    output logic [CW-1:0]        RD_COUNT,
    output logic [CW+SELW-1:0]   TOTAL,
    output logic [SELW-1:0]      WINNER,
    output logic                 TIE,
    output logic                 RESULT_VALID,
    output logic                 BUSY
);

    localparam int              TW     = CW + SELW;
    localparam logic [SELW:0]   NC_LIM = NCAND[SELW:0];

    evm_state_t          r_state;
    evm_state_t          w_state_nxt;
    logic                r_armed;
    logic                r_ack;
    logic                r_err;
    logic [CW-1:0]       r_tally [NCAND];
    logic [TW-1:0]       r_total;
    logic [SELW-1:0]     r_winner;
    logic                r_tie;
    logic                r_result_vld;

    logic                w_accept;
    logic                w_sel_ok;
    logic                w_open_ok;
    logic                w_scan_start;
    logic                w_scan_busy;
    logic                w_scan_done;
    logic [SELW-1:0]     w_scan_idx;
    logic                w_scan_tie;
    logic [NCAND*CW-1:0] w_tally_flat;
    logic [CW-1:0]       w_rd_count;

    assign VOTE_READY = (r_state == ST_ACCEPT) && r_armed;
    assign w_accept   = VOTE_VALID && VOTE_READY;
    assign w_sel_ok   = ({1'b0, VOTE_SEL} < NC_LIM);
    assign w_open_ok  = OPEN && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_scan_start = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (OPEN) w_state_nxt = ST_ACCEPT;
            end
            ST_ACCEPT: begin
                if (CLOSE) begin
                    w_state_nxt  = ST_SCAN;
                    w_scan_start = 1'b1;
                end
            end
            ST_SCAN: begin
                if (w_scan_done) w_state_nxt = ST_DONE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // A held key counts once: re-arm only after VALID has been seen low.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_armed <= 1'b1;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ack <= w_accept && w_sel_ok;
            r_err <= w_accept && !w_sel_ok;
            if (w_accept) begin
                r_armed <= 1'b0;
            end else if (!VOTE_VALID) begin
                r_armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int c = 0; c < NCAND; c++) r_tally[c] <= '0;
            r_total <= '0;
        end else if (w_open_ok) begin
            for (int c = 0; c < NCAND; c++) r_tally[c] <= '0;
            r_total <= '0;
        end else if (w_accept && w_sel_ok) begin
            for (int c = 0; c < NCAND; c++) begin
                if (VOTE_SEL == SELW'(c)) begin
                    r_tally[c] <= CW'(sat_inc(SAT_W'(r_tally[c]), CW));
                end
            end
            r_total <= TW'(sat_inc(SAT_W'(r_total), TW));
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_winner     <= '0;
            r_tie        <= 1'b0;
            r_result_vld <= 1'b0;
        end else if (w_open_ok) begin
            r_winner     <= '0;
            r_tie        <= 1'b0;
            r_result_vld <= 1'b0;
        end else if ((r_state == ST_SCAN) && w_scan_done) begin
            r_winner     <= w_scan_idx;
            r_tie        <= w_scan_tie;
            r_result_vld <= 1'b1;
        end
    end

    always_comb begin
        w_tally_flat = '0;
        w_rd_count   = '0;
        for (int c = 0; c < NCAND; c++) begin
            w_tally_flat[c*CW +: CW] = r_tally[c];
            if (RD_SEL == SELW'(c)) w_rd_count = r_tally[c];
        end
    end

    evm_max_scan #(
        .NCAND (NCAND),
        .CW    (CW),
        .SELW  (SELW)
    ) u_scan (
        .i_core_clk (CLK),
        .i_arst_n   (RESET),
        .i_start    (w_scan_start),
        .i_tally    (w_tally_flat),
        .o_busy     (w_scan_busy),
        .o_done     (w_scan_done),
        .o_best_idx (w_scan_idx),
        .o_tie      (w_scan_tie)
    );

    assign VOTE_ACK     = r_ack;
    assign VOTE_ERR     = r_err;
    assign RD_COUNT     = w_rd_count;
    assign TOTAL        = r_total;
    assign WINNER       = r_winner;
    assign TIE          = r_tie;
    assign RESULT_VALID = r_result_vld;
    // Covers the scanner plus the one-cycle handoff into DONE.
    assign BUSY         = (r_state == ST_SCAN) || w_scan_busy;

endmodule

// File: tb/tb_evm_param.sv
// Scoreboard bench for evm_param: a 4x32 instance for the main flow and a 3x3 instance
// for invalid-select and saturation cases.
module tb_evm_param;

    typedef struct {
        bit     err;
        longint cnt;
        longint tot;
    } vexp_t;

    typedef struct {
        int win;
        bit tie;
        int lat;
    } rexp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // DUT a: NCAND=4, CW=32
    logic        a_rst_n, a_open, a_close, a_vvld;
    logic [1:0]  a_vsel, a_rdsel;
    logic        a_vrdy, a_ack, a_err, a_tie, a_rv, a_busy;
    logic [31:0] a_rd_count;
    logic [33:0] a_total;
    logic [1:0]  a_winner;

    // DUT b: NCAND=3, CW=3
    logic        b_rst_n, b_open, b_close, b_vvld;
    logic [1:0]  b_vsel, b_rdsel;
    logic        b_vrdy, b_ack, b_err, b_tie, b_rv, b_busy;
    logic [2:0]  b_rd_count;
    logic [4:0]  b_total;
    logic [1:0]  b_winner;

    evm_param #(.NCAND(4), .CW(32)) u_a (
        .CLK(clk), .RESET(a_rst_n), .OPEN(a_open), .CLOSE(a_close),
        .VOTE_VALID(a_vvld), .VOTE_SEL(a_vsel), .VOTE_READY(a_vrdy),
        .VOTE_ACK(a_ack), .VOTE_ERR(a_err), .RD_SEL(a_rdsel), .RD_COUNT(a_rd_count),
        .TOTAL(a_total), .WINNER(a_winner), .TIE(a_tie), .RESULT_VALID(a_rv), .BUSY(a_busy)
    );

    evm_param #(.NCAND(3), .CW(3)) u_b (
        .CLK(clk), .RESET(b_rst_n), .OPEN(b_open), .CLOSE(b_close),
        .VOTE_VALID(b_vvld), .VOTE_SEL(b_vsel), .VOTE_READY(b_vrdy),
        .VOTE_ACK(b_ack), .VOTE_ERR(b_err), .RD_SEL(b_rdsel), .RD_COUNT(b_rd_count),
        .TOTAL(b_total), .WINNER(b_winner), .TIE(b_tie), .RESULT_VALID(b_rv), .BUSY(b_busy)
    );

    vexp_t  qa[$], qb[$];
    rexp_t  ra[$], rb[$];
    longint close_a = 0, close_b = 0;
    longint ma[4], mb[3];
    longint ta = 0, tb_t = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Vote monitors: every ACK/ERR pulse must match the oldest queued expectation.
    always @(negedge clk) begin : mon_vote_a
        vexp_t e;
        if (a_ack || a_err) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_vote_resp", 64'(1), 64'(0));
            end else begin
                e = qa.pop_front();
                chk("a_vote_err_flag", 64'(a_err), 64'(e.err));
                chk("a_vote_ack_flag", 64'(a_ack), 64'(!e.err));
                if (!e.err) begin
                    chk("a_rd_count_at_ack", 64'(a_rd_count), 64'(e.cnt));
                    chk("a_total_at_ack", 64'(a_total), 64'(e.tot));
                end
            end
        end
    end

    always @(negedge clk) begin : mon_vote_b
        vexp_t e;
        if (b_ack || b_err) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_vote_resp", 64'(1), 64'(0));
            end else begin
                e = qb.pop_front();
                chk("b_vote_err_flag", 64'(b_err), 64'(e.err));
                chk("b_vote_ack_flag", 64'(b_ack), 64'(!e.err));
                if (!e.err) begin
                    chk("b_rd_count_at_ack", 64'(b_rd_count), 64'(e.cnt));
                    chk("b_total_at_ack", 64'(b_total), 64'(e.tot));
                end
            end
        end
    end

    // Result monitors: on RESULT_VALID rising, compare winner/tie/latency from CLOSE edge.
    logic a_rv_q = 1'b0, b_rv_q = 1'b0;
    always @(negedge clk) begin : mon_res
        rexp_t r;
        if (a_rv && !a_rv_q) begin
            if (ra.size() == 0) chk("a_unexpected_result", 64'(1), 64'(0));
            else begin
                r = ra.pop_front();
                chk("a_winner", 64'(a_winner), 64'(r.win));
                chk("a_tie", 64'(a_tie), 64'(r.tie));
                chk("a_result_latency", 64'(cyc - close_a), 64'(r.lat));
            end
        end
        if (b_rv && !b_rv_q) begin
            if (rb.size() == 0) chk("b_unexpected_result", 64'(1), 64'(0));
            else begin
                r = rb.pop_front();
                chk("b_winner", 64'(b_winner), 64'(r.win));
                chk("b_tie", 64'(b_tie), 64'(r.tie));
                chk("b_result_latency", 64'(cyc - close_b), 64'(r.lat));
            end
        end
        a_rv_q = a_rv;
        b_rv_q = b_rv;
    end

    task automatic push_res(input bit b, input int win, input bit tie);
        rexp_t r;
        r.win = win;
        r.tie = tie;
        r.lat = b ? 4 : 5;
        if (b) rb.push_back(r); else ra.push_back(r);
    endtask

    task automatic pulse_open(input bit b);
        if (b) begin
            b_open = 1'b1;
            for (int i = 0; i < 3; i++) mb[i] = 0;
            tb_t = 0;
        end else begin
            a_open = 1'b1;
            for (int i = 0; i < 4; i++) ma[i] = 0;
            ta = 0;
        end
        tick();
        a_open = 1'b0;
        b_open = 1'b0;
    endtask

    task automatic do_close(input bit b);
        if (b) begin b_close = 1'b1; close_b = cyc + 1; end
        else   begin a_close = 1'b1; close_a = cyc + 1; end
        tick();
        a_close = 1'b0;
        b_close = 1'b0;
    endtask

    // counted=1 pushes the expected ACK/ERR; VALID is held 'hold' cycles then dropped.
    task automatic vote(input bit b, input int sel, input bit counted, input bit with_close, input int hold);
        vexp_t e;
        if (counted) begin
            e.err = b ? (sel >= 3) : (sel >= 4);
            e.cnt = 0;
            e.tot = 0;
            if (!e.err) begin
                if (b) begin
                    if (mb[sel] < 7) mb[sel]++;
                    if (tb_t < 31) tb_t++;
                    e.cnt = mb[sel];
                    e.tot = tb_t;
                end else begin
                    if (ma[sel] < 64'hFFFF_FFFF) ma[sel]++;
                    ta++;
                    e.cnt = ma[sel];
                    e.tot = ta;
                end
            end
            if (b) qb.push_back(e); else qa.push_back(e);
        end
        if (b) begin
            b_vsel = 2'(sel); b_rdsel = 2'(sel); b_vvld = 1'b1;
            if (with_close) begin b_close = 1'b1; close_b = cyc + 1; end
        end else begin
            a_vsel = 2'(sel); a_rdsel = 2'(sel); a_vvld = 1'b1;
            if (with_close) begin a_close = 1'b1; close_a = cyc + 1; end
        end
        tick();
        a_close = 1'b0;
        b_close = 1'b0;
        repeat (hold - 1) tick();
        a_vvld = 1'b0;
        b_vvld = 1'b0;
        tick();
    endtask

    task automatic rd(input bit b, input int sel, input longint exp, input string nm);
        if (b) b_rdsel = 2'(sel); else a_rdsel = 2'(sel);
        #1;
        chk(nm, b ? 64'(b_rd_count) : 64'(a_rd_count), 64'(exp));
    endtask

    task automatic wait_rv(input bit b);
        int n = 0;
        while (!(b ? b_rv : a_rv) && n < 50) begin
            tick();
            n++;
        end
        chk(b ? "b_result_timeout" : "a_result_timeout", 64'(b ? b_rv : a_rv), 64'(1));
        tick();
    endtask

    task automatic chk_a_cleared(input string tag);
        chk({tag, "_ready"}, 64'(a_vrdy), 64'(0));
        chk({tag, "_ack"}, 64'(a_ack), 64'(0));
        chk({tag, "_err"}, 64'(a_err), 64'(0));
        chk({tag, "_total"}, 64'(a_total), 64'(0));
        chk({tag, "_winner"}, 64'(a_winner), 64'(0));
        chk({tag, "_tie"}, 64'(a_tie), 64'(0));
        chk({tag, "_rv"}, 64'(a_rv), 64'(0));
        chk({tag, "_busy"}, 64'(a_busy), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        a_rst_n = 1'b0; a_open = 1'b0; a_close = 1'b0; a_vvld = 1'b0; a_vsel = '0; a_rdsel = '0;
        b_rst_n = 1'b0; b_open = 1'b0; b_close = 1'b0; b_vvld = 1'b0; b_vsel = '0; b_rdsel = '0;
        #3;
        chk_a_cleared("reset");
        chk("reset_b_ready", 64'(b_vrdy), 64'(0));
        tick();
        tick();
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        tick();

        // Votes in IDLE are ignored.
        vote(0, 1, 0, 0, 1);
        vote(0, 2, 0, 0, 1);
        chk("idle_total", 64'(a_total), 64'(0));
        rd(0, 1, 0, "idle_rd1");
        chk("idle_ready", 64'(a_vrdy), 64'(0));

        // Main flow.
        pulse_open(0);
        chk("open_ready", 64'(a_vrdy), 64'(1));
        vote(0, 2, 1, 0, 1);
        vote(0, 0, 1, 0, 1);
        vote(0, 1, 1, 0, 1);
        vote(0, 3, 1, 0, 1);
        vote(0, 1, 1, 0, 1);
        vote(0, 2, 1, 0, 1);
        vote(0, 1, 1, 0, 1);
        push_res(0, 1, 0);
        do_close(0);
        chk("scan_busy", 64'(a_busy), 64'(1));
        chk("scan_ready", 64'(a_vrdy), 64'(0));
        wait_rv(0);
        rd(0, 0, 1, "main_rd0");
        rd(0, 1, 3, "main_rd1");
        rd(0, 2, 2, "main_rd2");
        rd(0, 3, 1, "main_rd3");
        chk("main_total", 64'(a_total), 64'(7));
        chk("done_busy", 64'(a_busy), 64'(0));

        // Tie between candidates 0 and 2.
        pulse_open(0);
        rd(0, 0, 0, "reopen_rd0");
        chk("reopen_rv", 64'(a_rv), 64'(0));
        chk("reopen_total", 64'(a_total), 64'(0));
        vote(0, 0, 1, 0, 1);
        vote(0, 2, 1, 0, 1);
        vote(0, 2, 1, 0, 1);
        vote(0, 0, 1, 0, 1);
        push_res(0, 0, 1);
        do_close(0);
        wait_rv(0);

        // All-zero tallies.
        pulse_open(0);
        push_res(0, 0, 1);
        do_close(0);
        wait_rv(0);

        // Held key counts once, then reset in the middle of the scan.
        pulse_open(0);
        vote(0, 3, 1, 0, 10);
        rd(0, 3, 1, "held_rd3");
        chk("held_total", 64'(a_total), 64'(1));
        do_close(0);
        tick();
        tick();
        chk("midscan_busy", 64'(a_busy), 64'(1));
        #2;
        a_rst_n = 1'b0;
        #1;
        chk_a_cleared("async_reset");
        rd(0, 3, 0, "async_reset_rd3");
        tick();
        a_rst_n = 1'b1;
        tick();
        pulse_open(0);
        vote(0, 2, 1, 0, 1);
        push_res(0, 2, 0);
        do_close(0);
        wait_rv(0);

        // DUT b: invalid select, saturation, CLOSE coincident with a vote.
        pulse_open(1);
        vote(1, 3, 1, 0, 1);
        rd(1, 0, 0, "err_rd0");
        rd(1, 1, 0, "err_rd1");
        rd(1, 2, 0, "err_rd2");
        chk("err_total", 64'(b_total), 64'(0));
        for (int i = 0; i < 9; i++) vote(1, 0, 1, 0, 1);
        rd(1, 0, 7, "sat_rd0");
        chk("sat_total", 64'(b_total), 64'(9));
        push_res(1, 0, 0);
        vote(1, 1, 1, 1, 1);
        wait_rv(1);
        rd(1, 1, 1, "coinc_rd1");
        chk("coinc_total", 64'(b_total), 64'(10));

        tick();
        chk("qa_drained", 64'(qa.size()), 64'(0));
        chk("qb_drained", 64'(qb.size()), 64'(0));
        chk("ra_drained", 64'(ra.size()), 64'(0));
        chk("rb_drained", 64'(rb.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
